spi_flash_responder: RTL

//  SPI mode-0 target that answers the spi_master2v0 flash chip-select. Behaves as a reduced
//  W25Q16-style flash: small internal byte array, read/program/status commands, MISO tri-state

---
 rtl/spi_flash_responder.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_responder.sv
// spi_flash_responder
//   SPI mode-0 target emulating a reduced W25Q16-style serial flash: a small
//   byte array with READ (03), FAST_READ (0B), PAGE PROGRAM (02), WREN (06),
//   WRDI (04) and RDSR (05). All SPI pins are asynchronous to clk_i and are
//   oversampled; SCLK high and low phases must each last >= 2 clk_i cycles.
//
//   Optional feature macro: SPI_FLASH_RESP_FAST_READ_EN
//     defined     -> opcode 0B runs ADDR, one dummy byte, then data out
//     not defined -> opcode 0B is treated as unsupported (frame ignored)
//
// Parameters
//   ADDR_W     log2 of array depth; the 24-bit SPI address is truncated to it
//   INIT_BYTE  erased content of every array byte
//
// Ports
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   SCLK_i     serial clock from master (idle low)
//   cs_n_i     chip select, active low
//   MOSI_i     master-out serial data
//   MISO_o     slave-out serial data, MSB first, changes after SCLK fall
//   miso_oe_o  1 while MISO_o is driven (STATUS / DATA_OUT only)
//   wel_o      write-enable latch
//   frame_o    1 while a chip-select frame is being processed
//   cmd_o      opcode of the current/last frame

module spi_flash_responder #(
   parameter int unsigned ADDR_W    = 8,
   parameter logic [7:0]  INIT_BYTE = 8'hFF
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       SCLK_i,
   input  logic       cs_n_i,
   input  logic       MOSI_i,
   output logic       MISO_o,
   output logic       miso_oe_o,
   output logic       wel_o,
   output logic       frame_o,
   output logic [7:0] cmd_o
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   // Program addresses wrap inside a 256-byte page; upper bits stay fixed.
   localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'(8'hFF);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_CMD      = 3'd1;
   localparam logic [2:0] S_ADDR     = 3'd2;
   localparam logic [2:0] S_DUMMY    = 3'd3;
   localparam logic [2:0] S_DATA_OUT = 3'd4;
   localparam logic [2:0] S_DATA_IN  = 3'd5;
   localparam logic [2:0] S_STATUS   = 3'd6;
   localparam logic [2:0] S_IGNORE   = 3'd7;

   localparam logic [1:0] OP_READ = 2'd0;
   localparam logic [1:0] OP_FAST = 2'd1;
   localparam logic [1:0] OP_PROG = 2'd2;

   // Write-enable latch change deferred to the end of the frame.
   localparam logic [1:0] ACT_NONE = 2'd0;
   localparam logic [1:0] ACT_SET  = 2'd1;
   localparam logic [1:0] ACT_CLR  = 2'd2;

   // ---------------------------------------------------------------- sync
   logic [1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
   logic       sclk_prev_q;

   always_ff @(posedge clk_i) begin
      sclk_sync_q <= {sclk_sync_q[0], SCLK_i};
      cs_sync_q   <= {cs_sync_q[0], cs_n_i};
      mosi_sync_q <= {mosi_sync_q[0], MOSI_i};
      sclk_prev_q <= sclk_sync_q[1];
   end

   logic sclk_rise, sclk_fall, cs_high, mosi_s;
   assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
   assign sclk_fall = ~sclk_sync_q[1] & sclk_prev_q;
   assign cs_high   = cs_sync_q[1];
   assign mosi_s    = mosi_sync_q[1];

   // ---------------------------------------------------------------- state
   logic [2:0]        state_q, state_d;
   logic [2:0]        bit_q, bit_d;
   logic [1:0]        abyte_q, abyte_d;
   logic [6:0]        sh_q, sh_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        op_q, op_d;
   logic [1:0]        act_q, act_d;
   logic [7:0]        out_sh_q, out_sh_d;
   logic              miso_q, miso_d;
   logic              wel_q, wel_d;
   logic [7:0]        cmd_q, cmd_d;
   logic              armed_q, armed_d;

   // The array holds data XOR INIT_BYTE so that a zero-configured RAM reads
   // back as erased content without any reset or load sequence.
   logic [7:0] mem_q [DEPTH];
   logic       mem_we;
   logic [7:0] rx_byte, mem_rd, tx_byte;

   assign rx_byte = {sh_q, mosi_s};
   assign mem_rd  = mem_q[addr_q] ^ INIT_BYTE;

   always_comb begin
      state_d  = state_q;
      bit_d    = bit_q;
      abyte_d  = abyte_q;
      sh_d     = sh_q;
      addr_d   = addr_q;
      op_d     = op_q;
      act_d    = act_q;
      out_sh_d = out_sh_q;
      miso_d   = miso_q;
      wel_d    = wel_q;
      cmd_d    = cmd_q;
      armed_d  = armed_q;
      mem_we   = 1'b0;
      tx_byte  = '0;

      if (cs_high) begin
         // armed only re-arms on a visible CS-high, so a reset inside a
         // frame keeps the FSM idle until the master starts a new frame.
         armed_d = 1'b1;
         if (state_q != S_IDLE) begin
            state_d = S_IDLE;
            bit_d   = '0;
            abyte_d = '0;
            miso_d  = 1'b0;
            act_d   = ACT_NONE;
            if (act_q == ACT_SET)
               wel_d = 1'b1;
            else if (act_q == ACT_CLR)
               wel_d = 1'b0;
         end
      end else if (state_q == S_IDLE) begin
         if (armed_q) begin
            state_d = S_CMD;
            armed_d = 1'b0;
            bit_d   = '0;
            abyte_d = '0;
            act_d   = ACT_NONE;
            miso_d  = 1'b0;
         end
      end else begin
         if (sclk_rise) begin
            sh_d  = rx_byte[6:0];
            bit_d = bit_q + 3'd1;
            if (state_q == S_ADDR)
               addr_d = {addr_q[ADDR_W-2:0], mosi_s};
            if (bit_q == 3'd7) begin
               case (state_q)
                  S_CMD: begin
                     cmd_d   = rx_byte;
                     state_d = S_IGNORE;
                     case (rx_byte)
                        8'h06: act_d = ACT_SET;
                        8'h04: act_d = ACT_CLR;
                        8'h05: state_d = S_STATUS;
                        8'h03: begin
                           state_d = S_ADDR;
                           op_d    = OP_READ;
                        end
`ifdef SPI_FLASH_RESP_FAST_READ_EN
                        8'h0B: begin
                           state_d = S_ADDR;
                           op_d    = OP_FAST;
                        end
`endif
                        8'h02: begin
                           if (wel_q) begin
                              state_d = S_ADDR;
                              op_d    = OP_PROG;
                           end
                        end
                        default: ;
                     endcase
                  end
                  S_ADDR: begin
                     abyte_d = abyte_q + 2'd1;
                     if (abyte_q == 2'd2) begin
                        abyte_d = '0;
                        case (op_q)
                           OP_READ: state_d = S_DATA_OUT;
                           OP_FAST: state_d = S_DUMMY;
                           default: begin
                              state_d = S_DATA_IN;
                              act_d   = ACT_CLR;
                           end
                        endcase
                     end
                  end
                  S_DUMMY: state_d = S_DATA_OUT;
                  S_DATA_IN: begin
                     mem_we = 1'b1;
                     addr_d = (addr_q & ~PAGE_MASK) |
                              ((addr_q + ADDR_W'(1)) & PAGE_MASK);
                  end
                  default: ;
               endcase
            end
         end

         // bit_q == 0 on a fall means the previous byte boundary has just
         // passed: load the next byte and present its MSB.
         if (sclk_fall && (state_q == S_DATA_OUT || state_q == S_STATUS)) begin
            if (bit_q == 3'd0) begin
               tx_byte  = (state_q == S_STATUS) ? {6'b0, wel_q, 1'b0} : mem_rd;
               miso_d   = tx_byte[7];
               out_sh_d = {tx_byte[6:0], 1'b0};
               if (state_q == S_DATA_OUT)
                  addr_d = addr_q + ADDR_W'(1);
            end else begin
               miso_d   = out_sh_q[7];
               out_sh_d = {out_sh_q[6:0], 1'b0};
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         bit_q    <= '0;
         abyte_q  <= '0;
         sh_q     <= '0;
         addr_q   <= '0;
         op_q     <= OP_READ;
         act_q    <= ACT_NONE;
         out_sh_q <= '0;
         miso_q   <= 1'b0;
         wel_q    <= 1'b0;
         cmd_q    <= '0;
         armed_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         bit_q    <= bit_d;
         abyte_q  <= abyte_d;
         sh_q     <= sh_d;
         addr_q   <= addr_d;
         op_q     <= op_d;
         act_q    <= act_d;
         out_sh_q <= out_sh_d;
         miso_q   <= miso_d;
         wel_q    <= wel_d;
         cmd_q    <= cmd_d;
         armed_q  <= armed_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (mem_we && !rst_i)
         mem_q[addr_q] <= rx_byte ^ INIT_BYTE;
   end

   assign MISO_o    = miso_q;
   assign miso_oe_o = (state_q == S_STATUS) || (state_q == S_DATA_OUT);
   assign wel_o     = wel_q;
   assign frame_o   = (state_q != S_IDLE);
   assign cmd_o     = cmd_q;

endmodule
